// File: rtl/token_pkg.sv
// Shared token definitions for the dataflow token ring: field widths, token layout, arbiter modes.
package token_pkg;

  localparam int unsigned NODE_W = 16;
  localparam int unsigned GEN_W  = 12;
  localparam int unsigned OPR_W  = 32;
  localparam int unsigned WEN_W  = 2;

  typedef struct packed {
    logic [NODE_W-1:0] node;
    logic [GEN_W-1:0]  gen;
    logic [OPR_W-1:0]  opr0;
    logic [OPR_W-1:0]  opr1;
    logic [WEN_W-1:0]  wen;
  } token_t;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/token_rr_arb.sv
// N-way arbiter: round-robin from a rotating pointer, or fixed priority with channel 0 highest.
module token_rr_arb
  import token_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         req_i,
  input  logic                      advance_i,
  output logic [NUM_CH-1:0]         grant_o,
  output logic [$clog2(NUM_CH)-1:0] grant_idx_o
);

  localparam int unsigned IdxW = $clog2(NUM_CH);
  localparam arb_mode_e   Mode = (ARB_MODE == 0) ? ARB_RR : ARB_FIXED;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            found;
  int unsigned     cand;

  // Scan cyclically from ptr (or from 0 in fixed mode); first requester wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = (Mode == ARB_FIXED) ? k : (k + 32'(ptr_q)) % NUM_CH;
      if (!found && req_i[IdxW'(cand)]) begin
        found                = 1'b1;
        grant_o[IdxW'(cand)] = 1'b1;
        grant_idx_o          = IdxW'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (Mode == ARB_RR && advance_i) begin
      ptr_d = (grant_idx_o == IdxW'(NUM_CH - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/token_merge_n.sv
// N-channel synchronous token merge: arbitrates valid/ready token channels into one
// source-tagged output stream through a DEPTH-entry circular buffer.
module token_merge_n
  import token_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned NODE_W   = token_pkg::NODE_W,
  parameter int unsigned GEN_W    = token_pkg::GEN_W,
  parameter int unsigned OPR_W    = token_pkg::OPR_W,
  parameter int unsigned WEN_W    = token_pkg::WEN_W,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic [NUM_CH*NODE_W-1:0]  in_node,
  input  logic [NUM_CH*GEN_W-1:0]   in_gen,
  input  logic [NUM_CH*OPR_W-1:0]   in_opr0,
  input  logic [NUM_CH*OPR_W-1:0]   in_opr1,
  input  logic [NUM_CH*WEN_W-1:0]   in_wen,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NODE_W-1:0]         out_node,
  output logic [GEN_W-1:0]          out_gen,
  output logic [OPR_W-1:0]          out_opr0,
  output logic [OPR_W-1:0]          out_opr1,
  output logic [WEN_W-1:0]          out_wen,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      full
);

  localparam int unsigned ChW  = $clog2(NUM_CH);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ChW-1:0]    ch;
    logic [NODE_W-1:0] node;
    logic [GEN_W-1:0]  gen;
    logic [OPR_W-1:0]  opr0;
    logic [OPR_W-1:0]  opr1;
    logic [WEN_W-1:0]  wen;
  } entry_t;

  logic [NODE_W-1:0] node_a [NUM_CH];
  logic [GEN_W-1:0]  gen_a  [NUM_CH];
  logic [OPR_W-1:0]  opr0_a [NUM_CH];
  logic [OPR_W-1:0]  opr1_a [NUM_CH];
  logic [WEN_W-1:0]  wen_a  [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign node_a[i] = in_node[i*NODE_W +: NODE_W];
    assign gen_a[i]  = in_gen[i*GEN_W +: GEN_W];
    assign opr0_a[i] = in_opr0[i*OPR_W +: OPR_W];
    assign opr1_a[i] = in_opr1[i*OPR_W +: OPR_W];
    assign wen_a[i]  = in_wen[i*WEN_W +: WEN_W];
  end

  entry_t            mem_q [DEPTH];
  entry_t            wr_ent, rd_ent;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              full_q;
  logic [NUM_CH-1:0] grant;
  logic [ChW-1:0]    grant_idx;
  logic              push, pop;

  token_rr_arb #(
    .NUM_CH  (NUM_CH),
    .ARB_MODE(ARB_MODE)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_i      (in_valid),
    .advance_i  (push),
    .grant_o    (grant),
    .grant_idx_o(grant_idx)
  );

  // Ready keys off the registered full flag, so a pop never frees a slot in the same cycle.
  assign in_ready = grant & {NUM_CH{~full_q & rst}};
  assign push     = |(in_valid & in_ready);
  assign pop      = (count_q != '0) & out_ready;

  always_comb begin
    wr_ent      = '0;
    wr_ent.ch   = grant_idx;
    wr_ent.node = node_a[grant_idx];
    wr_ent.gen  = gen_a[grant_idx];
    wr_ent.opr0 = opr0_a[grant_idx];
    wr_ent.opr1 = opr1_a[grant_idx];
    wr_ent.wen  = wen_a[grant_idx];
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_ent;
        wr_ptr_q        <= (DEPTH == 1) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (DEPTH == 1) ? '0 : rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == CntW'(DEPTH));
    end
  end

  assign rd_ent    = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_node  = rd_ent.node;
  assign out_gen   = rd_ent.gen;
  assign out_opr0  = rd_ent.opr0;
  assign out_opr1  = rd_ent.opr1;
  assign out_wen   = rd_ent.wen;
  assign out_ch    = rd_ent.ch;
  assign full      = full_q;

endmodule

// File: doc/token_merge_n.md
# token_merge_n

Parametrised N-channel synchronous token merge for the dataflow token ring. It is the clocked successor to the two-input self-timed merge, which joined the switch-box and input-FIFO paths through a C-element. It arbitrates NUM_CH valid/ready token channels, carrying node, generation, two operands and memory write-enable, into one output stream through a DEPTH-entry output buffer. Arbitration is round-robin or fixed-priority, and each output token is tagged with its source channel.

## Interface
Parameters:
- NUM_CH, 2, number of input channels (≥2)
- NODE_W, 16, node field width
- GEN_W, 12, generation field width
- OPR_W, 32, operand width (opr0 and opr1)
- WEN_W, 2, memory write-enable width
- DEPTH, 2, output buffer entries (power of 2, ≥1)
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  NUM_CH  per-channel token valid
- in_ready  out  NUM_CH  per-channel token accepted this cycle
- in_node  in  NUM_CH*NODE_W  packed, channel i at [i*NODE_W +: NODE_W]
- in_gen  in  NUM_CH*GEN_W  packed the same way
- in_opr0, in_opr1  in  NUM_CH*OPR_W  packed operands
- in_wen  in  NUM_CH*WEN_W  packed write-enables
- out_valid  out  1  output token valid
- out_ready  in  1  downstream accepts
- out_node / out_gen / out_opr0 / out_opr1 / out_wen  out  field widths  output token
- out_ch  out  clog2(NUM_CH)  source channel of the output token
- full  out  1  buffer count == DEPTH (registered)

## Operation
- Handshake: a transfer happens when valid and ready are both high on a clk edge. A source must hold valid and payload until it is accepted. Valid must not depend on ready.
- Grant is combinational from in_valid and the arbiter state. At most one in_ready is high: `in_ready[i] = grant[i] & ~full`.
- Round-robin: grant goes to the first requesting channel at or after ptr, scanning cyclically. On acceptance, ptr ← grant+1 mod NUM_CH. ptr is unchanged when nothing is accepted or when full.
- Fixed priority: lowest-index requesting channel. ptr is unused.
- Accepted tokens are written to the circular buffer at wr_ptr together with their channel index.
- The output always presents the entry at rd_ptr. out_valid = (count ≠ 0).
- Push and pop in the same cycle: count is unchanged and both pointers advance (pointer width clog2(DEPTH), natural wrap).
- Push is never allowed while full, even if a pop occurs the same cycle, because ready comes from the registered count. DEPTH = 1 therefore sustains at most one token every 2 cycles; DEPTH ≥ 2 sustains 1 token per cycle.
- Payload fields pass through unmodified with no width conversion. Single-operand producers drive opr1 = 0.
- No token is dropped, duplicated or reordered within a channel.

## Timing
- Latency: token accepted at edge k appears on out_* after edge k (out_valid high in cycle k+1) if the buffer was empty.
- Reset (rst low, asynchronous):
  - count = 0, wr_ptr = rd_ptr = 0, ptr = 0
  - out_valid = 0, full = 0, in_ready = 0
  - buffer data and out_* payload are don't-care but driven to 0
- Reset mid-operation discards all buffered tokens. Deassertion is synchronised externally. The first grant after reset goes to the lowest-index requester.
- Empty with out_ready high: no pop and no underflow. Full with in_valid high: all in_ready stay 0 and the arbiter state is held.

## Structure
- Shared package token_pkg: token field width constants (NODE_W, GEN_W, OPR_W, WEN_W), packed struct token_t {node, gen, opr0, opr1, wen}, enum arb_mode_e {ARB_RR, ARB_FIXED}.
- One sub-module: token_rr_arb (NUM_CH, ARB_MODE). Inputs are req and advance; output is a one-hot grant plus its index. It holds ptr.
- Buffer, counters and field unpacking stay in token_merge_n.

## Test plan
- Single channel, NUM_CH=2: ch1 sends node=0x0012, gen=0x005, opr0=0xDEADBEEF, opr1=0, wen=2'b01 with out_ready=1 → matching token with out_ch=1 appears one cycle after acceptance; full stays 0.
- Round-robin, NUM_CH=4, all valid continuously, out_ready=1 → out_ch sequence 0,1,2,3,0,1,… at one token per cycle (DEPTH=2).
- ARB_MODE=1, channels 0 and 2 both valid for 3 tokens each → all three ch0 tokens out before any ch2 token; per-channel order preserved.
- Backpressure, DEPTH=2: out_ready=0, 3 tokens offered → 2 accepted, full=1, in_ready=0. out_ready=1 for one cycle → one pop, full=0 next cycle, third token accepted.
- Assert rst low mid-stream with 2 tokens buffered → out_valid, full, in_ready go 0 immediately. After release, the first output token is the next one offered; no stale data.
- Random valid/ready stress, NUM_CH=3, 10k cycles → scoreboard shows every token delivered exactly once, in per-channel order, and no channel is starved for more than NUM_CH grants in RR mode.
